// File: rtl/cart_loader.sv
// cart_loader: streams HPS download bytes into the cartridge ROM init port,
// strips an optional header, pads the image to a power of two and publishes
// the resulting address mask for ROM mirroring.
module cart_loader #(
    parameter int unsigned AW            = 17,
    parameter int unsigned HDR_LEN       = 0,
    parameter logic [7:0]  FILL          = 8'hFF,
    parameter int unsigned MIN_SIZE_LOG2 = 8
) (
    input  logic          CLK,
    input  logic          RESB,
    input  logic          DL_START,
    input  logic          DL_END,
    input  logic [7:0]    DL_DATA,
    input  logic          DL_VALID,
    output logic          DL_READY,
    output logic [AW-1:0] INIT_ADDR,
    output logic [7:0]    INIT_DATA,
    output logic          INIT_VALID,
    output logic [AW-1:0] SIZE_MASK,
    output logic          BUSY,
    output logic          DONE,
    output logic          OVERFLOW
);

    localparam int unsigned HW = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
    localparam logic [AW:0] CAP     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] MIN_CNT = (AW+1)'(1) << MIN_SIZE_LOG2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SKIP = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_START = (HDR_LEN > 0) ? S_SKIP : S_LOAD;

    logic [2:0]    state, state_d;
    logic [HW-1:0] hdr_cnt, hdr_cnt_d;
    logic [AW:0]   count, count_d;
    logic [AW:0]   count_m1_c;
    logic          xfer_c;
    logic          pad_done_c;
    logic          init_valid_d;
    logic [AW-1:0] init_addr_d;
    logic [7:0]    init_data_d;
    logic [AW-1:0] size_mask_d;
    logic          overflow_d;

    // Handshake and padding-termination decode.
    assign xfer_c     = DL_VALID & DL_READY;
    assign count_m1_c = count - (AW+1)'(1);
    assign pad_done_c = (count == CAP) ||
                        (((count & count_m1_c) == '0) && (count >= MIN_CNT));

    // Next-state, counter and write-port decode; DL_START overrides everything.
    always_comb begin
        state_d      = state;
        hdr_cnt_d    = hdr_cnt;
        count_d      = count;
        init_valid_d = 1'b0;
        init_addr_d  = INIT_ADDR;
        init_data_d  = INIT_DATA;
        size_mask_d  = SIZE_MASK;
        overflow_d   = OVERFLOW;

        if (DL_START) begin
            state_d     = S_START;
            hdr_cnt_d   = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            size_mask_d = '0;
        end else begin
            case (state)
                S_SKIP: begin
                    if (xfer_c) begin
                        hdr_cnt_d = hdr_cnt + HW'(1);
                        if (hdr_cnt == HW'(HDR_LEN - 1)) begin
                            state_d = S_LOAD;
                        end
                    end
                    if (DL_END) begin
                        state_d = S_PAD;
                    end
                end
                S_LOAD: begin
                    if (xfer_c) begin
                        if (count == CAP) begin
                            overflow_d = 1'b1;
                        end else begin
                            init_valid_d = 1'b1;
                            init_addr_d  = count[AW-1:0];
                            init_data_d  = DL_DATA;
                            count_d      = count + (AW+1)'(1);
                        end
                    end
                    if (DL_END) begin
                        state_d = S_PAD;
                    end
                end
                S_PAD: begin
                    if (pad_done_c) begin
                        size_mask_d = count_m1_c[AW-1:0];
                        state_d     = S_FIN;
                    end else begin
                        init_valid_d = 1'b1;
                        init_addr_d  = count[AW-1:0];
                        init_data_d  = FILL;
                        count_d      = count + (AW+1)'(1);
                    end
                end
                S_FIN: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state      <= S_IDLE;
            hdr_cnt    <= '0;
            count      <= '0;
            INIT_VALID <= 1'b0;
            INIT_ADDR  <= '0;
            INIT_DATA  <= '0;
            SIZE_MASK  <= '0;
            OVERFLOW   <= 1'b0;
            DL_READY   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_d;
            hdr_cnt    <= hdr_cnt_d;
            count      <= count_d;
            INIT_VALID <= init_valid_d;
            INIT_ADDR  <= init_addr_d;
            INIT_DATA  <= init_data_d;
            SIZE_MASK  <= size_mask_d;
            OVERFLOW   <= overflow_d;
            DL_READY   <= (state_d == S_SKIP) || (state_d == S_LOAD);
            BUSY       <= (state_d == S_SKIP) || (state_d == S_LOAD) || (state_d == S_PAD);
            DONE       <= (state_d == S_FIN);
        end
    end

endmodule
